// File: rtl/regfile_be.sv
// Byte-writable register file: two combinational read ports, optional write-to-read
// forwarding, optional hardwired-zero register 0 and a per-entry written-since-clear map.
module regfile_be #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 32,
    parameter bit               ZERO_REG0 = 1'b1,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int              NB        = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NB-1:0]    wbe,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic [DEPTH-1:0] dirty
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] dirty_q;
    logic             wr_ok;
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                     input logic [WIDTH-1:0] new_w,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    // An address is live when it names a real entry and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            if (a == AW'(n)) ok = 1'b1;
        end
        if (ZERO_REG0 && (a == '0)) ok = 1'b0;
        return ok;
    endfunction

    assign wr_ok = we && !clr && (|wbe) && addr_ok(waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) regs[n] <= RESET_VAL;
            dirty_q <= '0;
        end else if (clr) begin
            for (int n = 0; n < DEPTH; n++) regs[n] <= RESET_VAL;
            dirty_q <= '0;
        end else if (wr_ok) begin
            for (int n = 0; n < DEPTH; n++) begin
                if (waddr == AW'(n)) begin
                    regs[n]    <= merge_bytes(regs[n], wdata, wbe);
                    dirty_q[n] <= 1'b1;
                end
            end
        end
    end

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    // Zero-register and out-of-range reads win over forwarding.
    always_comb begin
        rdata[0] = '0;
        rdata[1] = '0;
        for (int p = 0; p < 2; p++) begin
            if (addr_ok(raddr[p])) begin
                for (int n = 0; n < DEPTH; n++) begin
                    if (raddr[p] == AW'(n)) rdata[p] = regs[n];
                end
                if (BYPASS && wr_ok && (waddr == raddr[p])) begin
                    rdata[p] = merge_bytes(rdata[p], wdata, wbe);
                end
            end
        end
    end

    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];
    assign dirty   = dirty_q;

endmodule

// File: tb/tb_regfile_be.sv
// Bench for regfile_be: two instances (32-deep zero-reg/bypass, 20-deep plain/no-bypass)
// share one stimulus stream and are compared against a per-instance behavioural model.
module tb_regfile_be;

    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'h5A5A_00C3;

    logic        clk = 1'b0;
    logic        rst_n, clr, we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic [31:0] dirty0;
    logic [19:0] dirty1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [2][32];
    logic [31:0] mdirty [2];

    always #5 clk = ~clk;

    regfile_be #(.WIDTH(32), .DEPTH(32), .ZERO_REG0(1'b1), .BYPASS(1'b1), .RESET_VAL(RV0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a0), .raddr_b(raddr_b), .rdata_b(rd_b0), .dirty(dirty0));

    regfile_be #(.WIDTH(32), .DEPTH(20), .ZERO_REG0(1'b0), .BYPASS(1'b0), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a1), .raddr_b(raddr_b), .rdata_b(rd_b1), .dirty(dirty1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] v, input logic [31:0] d,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = v;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit legal(input int inst, input logic [4:0] a);
        int depth;
        depth = (inst == 0) ? 32 : 20;
        if (int'(a) >= depth) return 1'b0;
        if (inst == 0 && a == 5'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input int inst, input logic [4:0] a);
        logic [31:0] v;
        if (!legal(inst, a)) return 32'h0;
        v = mem[inst][a];
        if (inst == 0 && we && !clr && wbe != 4'h0 && a == waddr) v = put_bytes(v, wdata, wbe);
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 32; n++) mem[i][n] = (i == 0) ? RV0 : RV1;
            mdirty[i] = 32'h0;
        end
    endtask

    task automatic m_edge();
        if (clr) begin
            m_reset();
        end else if (we && wbe != 4'h0) begin
            for (int i = 0; i < 2; i++) begin
                if (legal(i, waddr)) begin
                    mem[i][waddr]    = put_bytes(mem[i][waddr], wdata, wbe);
                    mdirty[i][waddr] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a0"}, {32'h0, rd_a0}, {32'h0, m_read(0, raddr_a)});
        chk({tag, ".b0"}, {32'h0, rd_b0}, {32'h0, m_read(0, raddr_b)});
        chk({tag, ".d0"}, {32'h0, dirty0}, {32'h0, mdirty[0]});
        chk({tag, ".a1"}, {32'h0, rd_a1}, {32'h0, m_read(1, raddr_a)});
        chk({tag, ".b1"}, {32'h0, rd_b1}, {32'h0, m_read(1, raddr_b)});
        chk({tag, ".d1"}, {44'h0, dirty1}, {44'h0, mdirty[1][19:0]});
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [3:0] be,
                         input logic [31:0] d, input logic [4:0] ra, input logic [4:0] rb);
        we = w; waddr = wa; wbe = be; wdata = d; raddr_a = ra; raddr_b = rb;
    endtask

    // Entered at posedge+1: check mid-cycle, take the edge, advance the model.
    task automatic cycle(input string tag);
        #3;
        check_all(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd1, 5'd19);
        cycle("reset");

        drive(1'b1, 5'd5, 4'hF, 32'hAABBCCDD, 5'd5, 5'd5);
        cycle("wr5_full");
        drive(1'b1, 5'd5, 4'b0101, 32'h11223344, 5'd5, 5'd4);
        cycle("wr5_part");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5);
        #1;
        chk("byte_merge", {32'h0, rd_a0}, {32'h0, 32'hAA22CC44});
        chk("dirty5", {63'h0, dirty0[5]}, 64'h1);
        cycle("hold");

        drive(1'b1, 5'd6, 4'h0, 32'hFFFFFFFF, 5'd6, 5'd5);
        cycle("wbe_zero");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd6, 5'd6);
        cycle("wbe_zero_after");

        drive(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle("zero_wr");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("zero_reg0", {32'h0, rd_a0}, 64'h0);
        chk("plain_reg0", {32'h0, rd_b1}, {32'h0, 32'hFFFFFFFF});
        cycle("zero_rd");

        drive(1'b1, 5'd7, 4'hF, 32'h12345678, 5'd7, 5'd2);
        cycle("wr7");
        drive(1'b1, 5'd7, 4'b0011, 32'h0000ABCD, 5'd7, 5'd7);
        #1;
        chk("bypass_on", {32'h0, rd_a0}, {32'h0, 32'h1234ABCD});
        chk("bypass_off", {32'h0, rd_a1}, {32'h0, 32'h12345678});
        cycle("bypass");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd7);
        #1;
        chk("bypass_off_after", {32'h0, rd_a1}, {32'h0, 32'h1234ABCD});
        cycle("bypass_after");

        drive(1'b1, 5'd25, 4'hF, 32'hCAFEF00D, 5'd25, 5'd19);
        cycle("wr25");
        drive(1'b1, 5'd19, 4'hF, 32'h0BADC0DE, 5'd25, 5'd19);
        cycle("wr19");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd25, 5'd19);
        #1;
        chk("oor_read", {32'h0, rd_a1}, 64'h0);
        chk("reg19", {32'h0, rd_b1}, {32'h0, 32'h0BADC0DE});
        cycle("oor_after");

        drive(1'b1, 5'd3, 4'hF, 32'hDEADBEEF, 5'd1, 5'd2);
        cycle("wr3");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3);
        #1;
        chk("dual_a", {32'h0, rd_a0}, {32'h0, 32'hDEADBEEF});
        chk("dual_b", {32'h0, rd_b0}, {32'h0, 32'hDEADBEEF});
        cycle("dual");

        clr = 1'b1;
        drive(1'b1, 5'd9, 4'hF, 32'h99999999, 5'd9, 5'd3);
        cycle("clr_we");
        clr = 1'b0;
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd3);
        #1;
        chk("clr_dirty", {32'h0, dirty0}, 64'h0);
        chk("clr_val1", {32'h0, rd_a1}, {32'h0, RV1});
        cycle("clr_after");

        drive(1'b1, 5'd11, 4'hF, 32'h76543210, 5'd11, 5'd12);
        cycle("pre_rst_a");
        drive(1'b1, 5'd12, 4'hF, 32'h01020304, 5'd11, 5'd12);
        cycle("pre_rst_b");
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd11, 5'd12);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_a0", {32'h0, rd_a0}, 64'h0);
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_rst");

        for (int k = 0; k < 400; k++) begin
            clr = ($urandom_range(63) == 0);
            drive(($urandom_range(7) != 0), 5'($urandom_range(31)), 4'($urandom_range(15)),
                  $urandom, 5'($urandom_range(31)), 5'($urandom_range(31)));
            cycle("rand");
        end
        clr = 1'b0;
        drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        for (int n = 0; n < 32; n++) begin
            raddr_a = 5'(n);
            raddr_b = 5'(31 - n);
            #1;
            check_all("sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
